// File: rtl/b_feeder_pkg.sv
// Shared types and helpers for the DSP B-operand feeder.
package b_feeder_pkg;

    typedef logic signed [17:0] operand_t;

    localparam int BREG_MAX = 2;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/b_feeder_fifo.sv
// Synchronous FIFO with combinational head; a push at full is taken only
// when a pop frees a slot in the same cycle.
module b_feeder_fifo
    import b_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 18
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DW-1:0]           data_i,
    output logic [DW-1:0]           head_o,
    output logic                    empty_o,
    output logic                    full_next_o,
    output logic [lvl_w(DEPTH)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;
    logic          full, do_push, do_pop;

    always_comb begin
        empty_o     = (level_q == '0);
        full        = (level_q == LW'(DEPTH));
        do_pop      = pop_i & ~empty_o;
        do_push     = push_i & (~full | do_pop);
        level_d     = level_q + LW'(do_push) - LW'(do_pop);
        full_next_o = (level_d == LW'(DEPTH));
        head_o      = mem_q[rd_q];
        level_o     = level_q;
    end

    // Memory is cleared so the head reads zero until the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/b_operand_feeder.sv
// Feeds a DSP slice's BREG-deep B register from a buffered valid/ready stream.
// Optional `define B_FEEDER_BUBBLE_SQUEEZE_EN lets stage 1 refill during a stall (BREG=2).
module b_operand_feeder
    import b_feeder_pkg::*;
#(
    parameter int BREG       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = 18
) (
    input  logic                         CLK,
    input  logic                         RSTB,
    input  logic [DW-1:0]                S_DATA,
    input  logic                         S_VALID,
    output logic                         S_READY,
    output logic [DW-1:0]                B,
    output logic                         CEB1,
    output logic                         CEB2,
    output logic                         M_VALID,
    input  logic                         M_READY,
    output logic [lvl_w(FIFO_DEPTH)-1:0] LEVEL
);

    logic run_q, s_ready_q;
    logic vld1_q, vld1_d, vld2_q, vld2_d;
    logic push, pop, empty, full_next;
    logic adv, ceb1, ceb2, m_valid;

    b_feeder_fifo #(
        .DEPTH(FIFO_DEPTH),
        .DW   (DW)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (RSTB),
        .push_i     (push),
        .pop_i      (pop),
        .data_i     (S_DATA),
        .head_o     (B),
        .empty_o    (empty),
        .full_next_o(full_next),
        .level_o    (LEVEL)
    );

    // run_q holds every clock enable low until the first edge after reset.
    always_comb begin
        push   = S_VALID & s_ready_q;
        ceb1   = 1'b0;
        ceb2   = 1'b0;
        pop    = 1'b0;
        vld1_d = vld1_q;
        vld2_d = vld2_q;
        if (BREG >= BREG_MAX) begin
            m_valid = vld2_q;
        end else if (BREG == 1) begin
            m_valid = vld1_q;
        end else begin
            m_valid = ~empty;
        end
        adv = run_q & (M_READY | ~m_valid);
        if (BREG >= BREG_MAX) begin
            ceb2 = adv;
`ifdef B_FEEDER_BUBBLE_SQUEEZE_EN
            ceb1 = run_q & (adv | ~vld1_q);
`else
            ceb1 = adv;
`endif
            pop = ceb1 & ~empty;
            if (ceb1) vld1_d = pop;
            if (ceb2) vld2_d = vld1_q;
        end else if (BREG == 1) begin
            ceb1 = adv;
            pop  = adv & ~empty;
            if (adv) vld1_d = pop;
            vld2_d = 1'b0;
        end else begin
            pop    = m_valid & adv;
            vld1_d = 1'b0;
            vld2_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            run_q     <= 1'b0;
            s_ready_q <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            s_ready_q <= ~full_next;
            vld1_q    <= vld1_d;
            vld2_q    <= vld2_d;
        end
    end

    assign S_READY = s_ready_q;
    assign CEB1    = ceb1;
    assign CEB2    = ceb2;
    assign M_VALID = m_valid;

endmodule

// File: tb/tb_b_operand_feeder.sv
// Directed bench for b_operand_feeder at BREG=2/1/0 with a model of the DSP B register.
module tb_b_operand_feeder;
    import b_feeder_pkg::*;

    logic        CLK, RSTB;
    logic [17:0] s_data;
    logic        s_valid, m_ready;

    logic        sr2, c1_2, c2_2, mv2;
    logic [17:0] b2;
    logic [2:0]  lvl2;
    logic        sr1, c1_1, c2_1, mv1;
    logic [17:0] b1;
    logic [2:0]  lvl1;
    logic        sr0, c1_0, c2_0, mv0;
    logic [17:0] b0;
    logic [2:0]  lvl0;

    operand_t x2_s1, x2_s2, x1_s1;

    int n_pass  = 0;
    int n_total = 0;

    b_operand_feeder #(.BREG(2), .FIFO_DEPTH(4), .DW(18)) u2 (
        .CLK(CLK), .RSTB(RSTB), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(sr2),
        .B(b2), .CEB1(c1_2), .CEB2(c2_2), .M_VALID(mv2), .M_READY(m_ready), .LEVEL(lvl2)
    );
    b_operand_feeder #(.BREG(1), .FIFO_DEPTH(4), .DW(18)) u1 (
        .CLK(CLK), .RSTB(RSTB), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(sr1),
        .B(b1), .CEB1(c1_1), .CEB2(c2_1), .M_VALID(mv1), .M_READY(m_ready), .LEVEL(lvl1)
    );
    b_operand_feeder #(.BREG(0), .FIFO_DEPTH(4), .DW(18)) u0 (
        .CLK(CLK), .RSTB(RSTB), .S_DATA(s_data), .S_VALID(s_valid), .S_READY(sr0),
        .B(b0), .CEB1(c1_0), .CEB2(c2_0), .M_VALID(mv0), .M_READY(m_ready), .LEVEL(lvl0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DSP B register pipelines driven by the feeders' clock enables.
    always @(posedge CLK) begin
        if (c1_2) x2_s1 <= b2;
        if (c2_2) x2_s2 <= x2_s1;
        if (c1_1) x1_s1 <= b1;
    end

    typedef struct {
        logic sv;
        int   sd;
        logic mr;
        logic e_sr;
        int   e_lvl;
        logic e_mv;
        logic e_c1;
        logic e_c2;
        int   e_x;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sv, input int sd, input logic mr,
                                input logic sr, input int lvl, input logic mv,
                                input logic c1, input logic c2, input int x);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr;
        v.e_sr = sr; v.e_lvl = lvl; v.e_mv = mv; v.e_c1 = c1; v.e_c2 = c2; v.e_x = x;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Each record: inputs driven at negedge, outputs checked 1 time unit later.
    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge CLK);
            s_valid = vecs[i].sv;
            s_data  = 18'(vecs[i].sd);
            m_ready = vecs[i].mr;
            #1;
            chk($sformatf("%s[%0d] S_READY", tag, i), int'(sr2), int'(vecs[i].e_sr));
            chk($sformatf("%s[%0d] LEVEL", tag, i), int'(lvl2), vecs[i].e_lvl);
            chk($sformatf("%s[%0d] M_VALID", tag, i), int'(mv2), int'(vecs[i].e_mv));
            chk($sformatf("%s[%0d] CEB1", tag, i), int'(c1_2), int'(vecs[i].e_c1));
            chk($sformatf("%s[%0d] CEB2", tag, i), int'(c2_2), int'(vecs[i].e_c2));
            if (vecs[i].e_mv)
                chk($sformatf("%s[%0d] X_MUX_B", tag, i), int'(x2_s2), vecs[i].e_x);
        end
        vecs.delete();
    endtask

    initial begin
        RSTB = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        #12;
        chk("rst S_READY", int'(sr2), 0);
        chk("rst LEVEL", int'(lvl2), 0);
        chk("rst M_VALID", int'(mv2), 0);
        chk("rst CEB1", int'(c1_2), 0);
        chk("rst CEB2", int'(c2_2), 0);
        chk("rst B", int'($signed(b2)), 0);
        chk("rst B0 M_VALID", int'(mv0), 0);
        @(posedge CLK); #3; RSTB = 1'b1;

        // 1: back-to-back 5,-7,3 with the consumer always ready
        vecs.push_back(mk(0,  0, 1, 0, 0, 0, 0, 0,  0));
        vecs.push_back(mk(1,  5, 1, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(1, -7, 1, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1,  3, 1, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(0,  0, 1, 1, 1, 1, 1, 1,  5));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, -7));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1,  3));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
        run_vecs("burst");

        // 2: six operands into a stalled consumer, then drain
        vecs.push_back(mk(1, 10, 0, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(1, 11, 0, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1, 12, 0, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1, 13, 0, 1, 1, 1, 0, 0, 10));
        vecs.push_back(mk(1, 14, 0, 1, 2, 1, 0, 0, 10));
        vecs.push_back(mk(1, 15, 0, 1, 3, 1, 0, 0, 10));
        vecs.push_back(mk(1, 16, 0, 0, 4, 1, 0, 0, 10));
        vecs.push_back(mk(0,  0, 1, 0, 4, 1, 1, 1, 10));
        vecs.push_back(mk(0,  0, 1, 1, 3, 1, 1, 1, 11));
        vecs.push_back(mk(0,  0, 1, 1, 2, 1, 1, 1, 12));
        vecs.push_back(mk(0,  0, 1, 1, 1, 1, 1, 1, 13));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 14));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 15));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
        run_vecs("stall");

        // 3: fill to full, release with input held, steady push+pop
        vecs.push_back(mk(1, 20, 0, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(1, 21, 0, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1, 22, 0, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1, 23, 0, 1, 1, 1, 0, 0, 20));
        vecs.push_back(mk(1, 24, 0, 1, 2, 1, 0, 0, 20));
        vecs.push_back(mk(1, 25, 0, 1, 3, 1, 0, 0, 20));
        vecs.push_back(mk(1, 26, 1, 0, 4, 1, 1, 1, 20));
        vecs.push_back(mk(1, 26, 1, 1, 3, 1, 1, 1, 21));
        vecs.push_back(mk(1, 27, 1, 1, 3, 1, 1, 1, 22));
        vecs.push_back(mk(0,  0, 1, 1, 3, 1, 1, 1, 23));
        vecs.push_back(mk(0,  0, 1, 1, 2, 1, 1, 1, 24));
        vecs.push_back(mk(0,  0, 1, 1, 1, 1, 1, 1, 25));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 26));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 27));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
        run_vecs("full");

        // 4: push, idle, push, then a 3-cycle stall
        vecs.push_back(mk(1, 40, 0, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(0,  0, 0, 1, 1, 0, 1, 1,  0));
        vecs.push_back(mk(1, 41, 0, 1, 0, 0, 1, 1,  0));
`ifdef B_FEEDER_BUBBLE_SQUEEZE_EN
        vecs.push_back(mk(0,  0, 0, 1, 1, 1, 1, 0, 40));
        vecs.push_back(mk(0,  0, 0, 1, 0, 1, 0, 0, 40));
        vecs.push_back(mk(0,  0, 0, 1, 0, 1, 0, 0, 40));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 40));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 41));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
`else
        vecs.push_back(mk(0,  0, 0, 1, 1, 1, 0, 0, 40));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1, 0, 0, 40));
        vecs.push_back(mk(0,  0, 0, 1, 1, 1, 0, 0, 40));
        vecs.push_back(mk(0,  0, 1, 1, 1, 1, 1, 1, 40));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
        vecs.push_back(mk(0,  0, 1, 1, 0, 1, 1, 1, 41));
        vecs.push_back(mk(0,  0, 1, 1, 0, 0, 1, 1,  0));
`endif
        run_vecs("gap");

        // 5: asynchronous reset in the middle of a stalled burst
        @(negedge CLK); s_valid = 1'b1; s_data = 18'd50; m_ready = 1'b0;
        @(negedge CLK); s_data = 18'd51;
        @(negedge CLK); s_data = 18'd52;
        @(negedge CLK); s_valid = 1'b0; #1;
        chk("pre-rst M_VALID", int'(mv2), 1);
        chk("pre-rst LEVEL", int'(lvl2), 1);
        chk("pre-rst S_READY", int'(sr2), 1);
        #1; RSTB = 1'b0; #1;
        chk("async S_READY", int'(sr2), 0);
        chk("async LEVEL", int'(lvl2), 0);
        chk("async M_VALID", int'(mv2), 0);
        chk("async CEB1", int'(c1_2), 0);
        chk("async CEB2", int'(c2_2), 0);
        chk("async B", int'($signed(b2)), 0);
        @(posedge CLK); @(posedge CLK); #3; RSTB = 1'b1;

        // 6: BREG=1 / BREG=0 latency with full-scale signed operands
        @(negedge CLK); s_valid = 1'b0; m_ready = 1'b1; #1;
        chk("post-rst S_READY", int'(sr2), 0);
        chk("post-rst LEVEL", int'(lvl2), 0);
        chk("post-rst M_VALID", int'(mv2), 0);
        @(negedge CLK); s_valid = 1'b1; s_data = 18'h20000; #1;
        chk("post-rst S_READY up", int'(sr2), 1);
        chk("post-rst LEVEL idle", int'(lvl2), 0);
        chk("post-rst M_VALID idle", int'(mv2), 0);
        chk("b0 M_VALID e1", int'(mv0), 0);
        chk("b1 M_VALID e1", int'(mv1), 0);
        @(negedge CLK); s_data = 18'h1FFFF; #1;
        chk("b0 M_VALID e2", int'(mv0), 1);
        chk("b0 B e2", int'($signed(b0)), -131072);
        chk("b0 CEB1", int'(c1_0), 0);
        chk("b0 CEB2", int'(c2_0), 0);
        chk("b1 M_VALID e2", int'(mv1), 0);
        chk("b1 LEVEL e2", int'(lvl1), 1);
        @(negedge CLK); s_valid = 1'b0; #1;
        chk("b0 M_VALID e3", int'(mv0), 1);
        chk("b0 B e3", int'($signed(b0)), 131071);
        chk("b1 M_VALID e3", int'(mv1), 1);
        chk("b1 X_MUX_B e3", int'(x1_s1), -131072);
        chk("b1 CEB1", int'(c1_1), 1);
        chk("b1 CEB2", int'(c2_1), 0);
        @(negedge CLK); #1;
        chk("b0 M_VALID e4", int'(mv0), 0);
        chk("b0 LEVEL e4", int'(lvl0), 0);
        chk("b1 M_VALID e4", int'(mv1), 1);
        chk("b1 X_MUX_B e4", int'(x1_s1), 131071);
        @(negedge CLK); #1;
        chk("b1 M_VALID e5", int'(mv1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
